// File: rtl/syzygy_dac_spi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// syzygy_dac_spi_pkg
//   Shared definitions for the DAC SPI arbiter:
//   - SPI register-port widths and read/write encodings
//   - arbiter FSM state encoding
//   - requester indices (0 = DAC init/config controller, 1 = host/PS path)
//   - the latched SPI command record and a read-data helper
// -----------------------------------------------------------------------------
package syzygy_dac_spi_pkg;

  localparam int SPI_REG_W  = 6;
  localparam int SPI_DATA_W = 8;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

  // Requester indices; also the value stored in the owner / last-grant flops.
  localparam logic REQ_CTRL = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a request, ready may be given
    ST_ISSUE = 2'd1,  // one-cycle spi_send pulse
    ST_WAIT  = 2'd2,  // waiting for spi_done, timeout counter running
    ST_RESP  = 2'd3   // one-cycle response strobe to the owner
  } arb_state_e;

  // One SPI register-port command as latched on the request handshake.
  // Field order matches {reqN_reg, reqN_data, reqN_rw}.
  typedef struct packed {
    logic [SPI_REG_W-1:0]  addr;
    logic [SPI_DATA_W-1:0] data;
    logic                  rw;
  } spi_cmd_t;

  // Writes return 0x00 to the requester; only reads carry SPI data back.
  function automatic logic [SPI_DATA_W-1:0] read_data_or_zero(
    input logic                  rw,
    input logic [SPI_DATA_W-1:0] data
  );
    return (rw == SPI_RW_READ) ? data : '0;
  endfunction

endpackage

// File: rtl/syzygy_dac_spi_arbiter_if.sv
// -----------------------------------------------------------------------------
// syzygy_dac_spi_arbiter_if
//   One requester's command/response channel into the DAC SPI arbiter.
//   Request  : req_valid/req_ready handshake carrying req_reg, req_data, req_rw
//              (req_rw 1 = read, 0 = write).
//   Response : rsp_valid one-cycle strobe; rsp_data (0x00 on write/timeout)
//              and rsp_timeout are meaningful only while rsp_valid is high.
//   Modports : master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface syzygy_dac_spi_arbiter_if;
  import syzygy_dac_spi_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [SPI_REG_W-1:0]  req_reg;
  logic [SPI_DATA_W-1:0] req_data;
  logic                  req_rw;

  logic                  rsp_valid;
  logic [SPI_DATA_W-1:0] rsp_data;
  logic                  rsp_timeout;

  modport master (
    output req_valid, req_reg, req_data, req_rw,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_rw,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );

endinterface

// File: rtl/syzygy_rr_grant2.sv
// -----------------------------------------------------------------------------
// syzygy_rr_grant2
//   Two-way round-robin grant. While en is high, grant is a combinational
//   one-hot (or zero) subset of req: a lone request wins outright, a tie goes
//   to the requester that did not win last time. last_grant updates only when
//   a grant is actually issued (the grant doubles as the requester's ready, so
//   grant implies handshake).
//
//   Ports:
//     clk, reset  clock, asynchronous active-high reset (last_grant -> 1)
//     en          arbitration window (arbiter idle)
//     req[1:0]    request valids, bit N = requester N
//     grant[1:0]  one-hot grant / ready, bit N = requester N
// -----------------------------------------------------------------------------
module syzygy_rr_grant2
  import syzygy_dac_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // NOTE: every output of a combinational block gets a default before any
  // branch so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (en) begin
      if (req == 2'b11) begin
        grant = (last_grant_q == REQ_HOST) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
      if (grant != 2'b00) begin
        last_grant_d = grant[1];  // index of the winner
      end
    end
  end

  // Reset to "host won last" so the DAC controller wins the first tie.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_HOST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/syzygy_dac_spi_arbiter.sv
// -----------------------------------------------------------------------------
// syzygy_dac_spi_arbiter
//   Shares the single DAC SPI master register port between the DAC
//   init/config controller (req0) and the host register-access path (req1).
//   One transaction at a time: grant (round-robin) -> issue spi_send ->
//   wait for spi_done with a timeout -> one-cycle response to the owner.
//
//   Latency: handshake at N, spi_send at N+1, earliest accepted spi_done at
//   N+2, rsp_valid at N+3, next handshake possible at N+4.
//
//   Parameters:
//     TIMEOUT_CYCLES  cycles allowed in WAIT before abort (>= 4)
//     TMO_W           timeout counter width, must hold TIMEOUT_CYCLES-1
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     req0, req1      requester channels (slave side), see the interface
//     spi_reg         SPI register address, stable from ISSUE through WAIT
//     spi_data_in     SPI write data, stable from ISSUE through WAIT
//     spi_rw          SPI direction (1 = read), stable from ISSUE through WAIT
//     spi_send        one-cycle start pulse (ISSUE)
//     spi_done        SPI master completion, honoured only in WAIT
//     spi_data_out    SPI read data, valid with spi_done
//     busy            high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module syzygy_dac_spi_arbiter
  import syzygy_dac_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_W          = 11
) (
  input  logic                   clk,
  input  logic                   reset,

  syzygy_dac_spi_arbiter_if.slave req0,
  syzygy_dac_spi_arbiter_if.slave req1,

  output logic [SPI_REG_W-1:0]   spi_reg,
  output logic [SPI_DATA_W-1:0]  spi_data_in,
  output logic                   spi_rw,
  output logic                   spi_send,
  input  logic                   spi_done,
  input  logic [SPI_DATA_W-1:0]  spi_data_out,

  output logic                   busy
);

  // Last WAIT count before the transaction is declared timed out: WAIT is
  // entered with the counter at 0, so RESP follows exactly TIMEOUT_CYCLES
  // cycles after WAIT entry when no done arrives.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q,     state_d;
  spi_cmd_t              cmd_q,       cmd_d;
  logic                  owner_q,     owner_d;
  logic [TMO_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
  logic [SPI_DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [SPI_DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic                  rsp0_tmo_q,  rsp0_tmo_d;
  logic                  rsp1_tmo_q,  rsp1_tmo_d;

  logic                  idle;
  logic [1:0]            grant;
  spi_cmd_t              ctrl_cmd;
  spi_cmd_t              host_cmd;

  // Per-transaction completion result, folded into the owner's registers.
  logic                  finish;
  logic [SPI_DATA_W-1:0] fin_data;
  logic                  fin_tmo;

  assign idle     = (state_q == ST_IDLE);
  assign ctrl_cmd = {req0.req_reg, req0.req_data, req0.req_rw};
  assign host_cmd = {req1.req_reg, req1.req_data, req1.req_rw};

  // Grant is only offered in IDLE, so ready can never be seen mid-transaction
  // and a requester that drops valid before ready leaves no trace.
  syzygy_rr_grant2 u_grant (
    .clk   (clk),
    .reset (reset),
    .en    (idle),
    .req   ({req1.req_valid, req0.req_valid}),
    .grant (grant)
  );

  assign req0.req_ready = grant[0];
  assign req1.req_ready = grant[1];

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    tmo_cnt_d   = tmo_cnt_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    rsp0_tmo_d  = rsp0_tmo_q;
    rsp1_tmo_d  = rsp1_tmo_q;
    finish      = 1'b0;
    fin_data    = '0;
    fin_tmo     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // spi_done is deliberately not looked at here.
        if (grant != 2'b00) begin
          owner_d = grant[1];
          cmd_d   = grant[1] ? host_cmd : ctrl_cmd;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A done seen here belongs to nothing we issued; it is dropped.
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // Done is tested first so it wins over the terminal count.
        if (spi_done) begin
          finish   = 1'b1;
          fin_data = read_data_or_zero(cmd_q.rw, spi_data_out);
        end else if (tmo_cnt_q == TMO_LAST) begin
          finish  = 1'b1;
          fin_tmo = 1'b1;
        end else begin
          // Only reached below TMO_LAST, so the counter can never wrap.
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Response data/timeout are per requester and held until that
    // requester's next response.
    if (finish) begin
      state_d = ST_RESP;
      if (owner_q == REQ_HOST) begin
        rsp1_data_d = fin_data;
        rsp1_tmo_d  = fin_tmo;
      end else begin
        rsp0_data_d = fin_data;
        rsp0_tmo_d  = fin_tmo;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops straight back to IDLE with everything
  // cleared; an in-flight transaction gets no response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      owner_q     <= REQ_CTRL;
      tmo_cnt_q   <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      rsp0_tmo_q  <= 1'b0;
      rsp1_tmo_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      owner_q     <= owner_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      rsp0_tmo_q  <= rsp0_tmo_d;
      rsp1_tmo_q  <= rsp1_tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from flops, so none can glitch into the SPI master.
  // ---------------------------------------------------------------------------
  assign spi_reg     = cmd_q.addr;
  assign spi_data_in = cmd_q.data;
  assign spi_rw      = cmd_q.rw;
  assign spi_send    = (state_q == ST_ISSUE);
  assign busy        = !idle;

  assign req0.rsp_valid   = (state_q == ST_RESP) && (owner_q == REQ_CTRL);
  assign req0.rsp_data    = rsp0_data_q;
  assign req0.rsp_timeout = rsp0_tmo_q;

  assign req1.rsp_valid   = (state_q == ST_RESP) && (owner_q == REQ_HOST);
  assign req1.rsp_data    = rsp1_data_q;
  assign req1.rsp_timeout = rsp1_tmo_q;

endmodule

// File: tb/tb_syzygy_dac_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_syzygy_dac_spi_arbiter
//   Self-checking bench for syzygy_dac_spi_arbiter (TIMEOUT_CYCLES = 16).
//   A transaction-level model decides the winner (round-robin on ties), the
//   expected SPI command, and the expected response (read data, 0x00 on
//   writes, timeout when done never comes within the window). The bench steps
//   the clock and plays the SPI master, sampling outputs 1 time unit after
//   each rising edge.
// -----------------------------------------------------------------------------
module tb_syzygy_dac_spi_arbiter;
  import syzygy_dac_spi_pkg::*;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] spi_reg;
  logic [7:0] spi_data_in;
  logic       spi_rw;
  logic       spi_send;
  logic       spi_done;
  logic [7:0] spi_data_out;
  logic       busy;

  syzygy_dac_spi_arbiter_if req0_if ();
  syzygy_dac_spi_arbiter_if req1_if ();

  syzygy_dac_spi_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .TMO_W          (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0_if),
    .req1         (req1_if),
    .spi_reg      (spi_reg),
    .spi_data_in  (spi_data_in),
    .spi_rw       (spi_rw),
    .spi_send     (spi_send),
    .spi_done     (spi_done),
    .spi_data_out (spi_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_last;  // requester that won most recently; 1 out of reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return 1 - model_last;
    return v1 ? 1 : 0;
  endfunction

  task automatic drive_req(input int n, input bit v, input spi_cmd_t c);
    if (n == 0) begin
      req0_if.req_valid = v;
      req0_if.req_reg   = c.addr;
      req0_if.req_data  = c.data;
      req0_if.req_rw    = c.rw;
    end else begin
      req1_if.req_valid = v;
      req1_if.req_reg   = c.addr;
      req1_if.req_data  = c.data;
      req1_if.req_rw    = c.rw;
    end
  endtask

  // One full transaction starting in an IDLE window. done_k is the WAIT
  // cycle (0-based) in which the SPI model raises done; outside 0..TMO-1 it
  // never does. stale raises done during the ISSUE cycle. hold keeps both
  // valids asserted after the handshake.
  task automatic do_txn(input string t, input bit v0, input spi_cmd_t c0,
                        input bit v1, input spi_cmd_t c1, input int done_k,
                        input logic [7:0] rdata, input bit stale, input bit hold);
    int       own;
    spi_cmd_t c;
    bit       done_ok;
    logic [7:0] exp_data;
    own      = pick(v0, v1);
    c        = (own == 1) ? c1 : c0;
    done_ok  = (done_k >= 0) && (done_k < TMO);
    exp_data = (done_ok && c.rw == SPI_RW_READ) ? rdata : 8'h00;

    spi_done = 1'b0;
    drive_req(0, v0, c0);
    drive_req(1, v1, c1);
    #1;
    check({t, " idle_busy"}, busy, 0);
    check({t, " ready0"}, req0_if.req_ready, own == 0);
    check({t, " ready1"}, req1_if.req_ready, own == 1);
    model_last = own;

    step();  // ISSUE
    spi_done     = stale;
    spi_data_out = ~rdata;
    if (!hold) begin
      req0_if.req_valid = 1'b0;
      req1_if.req_valid = 1'b0;
    end
    #1;
    check({t, " issue_ctl"}, {spi_send, busy, req0_if.req_ready, req1_if.req_ready}, 4'b1100);
    check({t, " issue_cmd"}, {spi_reg, spi_data_in, spi_rw}, c);

    step();  // WAIT cycle 0
    for (int k = 0; k < TMO; k++) begin
      check({t, " wait_ctl"},
            {spi_send, busy, req0_if.rsp_valid, req1_if.rsp_valid, req0_if.req_ready, req1_if.req_ready},
            6'b010000);
      check({t, " wait_cmd"}, {spi_reg, spi_data_in, spi_rw}, c);
      spi_done     = (k == done_k);
      spi_data_out = rdata;
      step();
      if (k == done_k) break;
    end

    // Response window: done one cycle earlier, or TMO cycles after WAIT entry.
    spi_done = 1'b0;
    check({t, " rsp_valid0"}, req0_if.rsp_valid, own == 0);
    check({t, " rsp_valid1"}, req1_if.rsp_valid, own == 1);
    if (own == 0) begin
      check({t, " rsp_data"}, req0_if.rsp_data, exp_data);
      check({t, " rsp_tmo"},  req0_if.rsp_timeout, !done_ok);
    end else begin
      check({t, " rsp_data"}, req1_if.rsp_data, exp_data);
      check({t, " rsp_tmo"},  req1_if.rsp_timeout, !done_ok);
    end

    step();  // back in IDLE
    check({t, " end_idle"}, {busy, spi_send, req0_if.rsp_valid, req1_if.rsp_valid}, 4'b0000);
  endtask

  spi_cmd_t   ca, cb, cz;
  logic [31:0] r;

  initial begin
    cz           = '0;
    reset        = 1'b1;
    spi_done     = 1'b0;
    spi_data_out = 8'h00;
    drive_req(0, 1'b0, cz);
    drive_req(1, 1'b0, cz);
    model_last   = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Reset state
    check("rst busy_send", {busy, spi_send}, 2'b00);
    check("rst spi_cmd", {spi_reg, spi_data_in, spi_rw}, 15'h0);
    check("rst rsp0", {req0_if.rsp_valid, req0_if.rsp_data, req0_if.rsp_timeout}, 10'h0);
    check("rst rsp1", {req1_if.rsp_valid, req1_if.rsp_data, req1_if.rsp_timeout}, 10'h0);

    // No request, spurious done in IDLE: nothing happens
    spi_done = 1'b1;
    #1;
    check("noreq ready", {req0_if.req_ready, req1_if.req_ready}, 2'b00);
    step();
    spi_done = 1'b0;
    check("noreq idle", {busy, spi_send, req0_if.rsp_valid, req1_if.rsp_valid}, 4'b0000);

    // Single write from req0, done 5 cycles after send
    ca = '{addr: 6'h0A, data: 8'h3F, rw: SPI_RW_WRITE};
    do_txn("wr0", 1'b1, ca, 1'b0, cz, 4, 8'hEE, 1'b0, 1'b0);

    // Read from req1
    cb = '{addr: 6'h1F, data: 8'h00, rw: SPI_RW_READ};
    do_txn("rd1", 1'b0, cz, 1'b1, cb, 2, 8'hA5, 1'b0, 1'b0);

    // Contention: both held valid, grants must alternate
    ca = '{addr: 6'h01, data: 8'h10, rw: SPI_RW_WRITE};
    cb = '{addr: 6'h02, data: 8'h20, rw: SPI_RW_READ};
    for (int i = 0; i < 4; i++) begin
      check("cont order", pick(1'b1, 1'b1), i % 2);
      do_txn("cont", 1'b1, ca, 1'b1, cb, 1, 8'h40 + 8'(i), 1'b0, 1'b1);
    end
    drive_req(0, 1'b0, cz);
    drive_req(1, 1'b0, cz);

    // Timeout, then a normal request
    ca = '{addr: 6'h05, data: 8'h11, rw: SPI_RW_READ};
    do_txn("tmo", 1'b1, ca, 1'b0, cz, -1, 8'h77, 1'b0, 1'b0);
    do_txn("after_tmo", 1'b1, ca, 1'b0, cz, 0, 8'h3C, 1'b0, 1'b0);

    // Done on the terminal WAIT cycle wins; stale done in ISSUE ignored
    cb = '{addr: 6'h22, data: 8'h00, rw: SPI_RW_READ};
    do_txn("late_done", 1'b0, cz, 1'b1, cb, TMO - 1, 8'h5C, 1'b1, 1'b0);
    do_txn("stale", 1'b1, ca, 1'b0, cz, 3, 8'h99, 1'b1, 1'b0);

    // Reset mid-WAIT on a req0 transaction (DUT last grant becomes 0)
    ca = '{addr: 6'h33, data: 8'hC3, rw: SPI_RW_WRITE};
    drive_req(0, 1'b1, ca);
    #1;
    check("abort ready0", req0_if.req_ready, 1);
    step();  // ISSUE
    drive_req(0, 1'b0, cz);
    step();  // WAIT 0
    step();  // WAIT 1
    check("abort in_wait", busy, 1);
    reset = 1'b1;
    #1;
    check("abort busy_send", {busy, spi_send}, 2'b00);
    check("abort rsp", {req0_if.rsp_valid, req1_if.rsp_valid}, 2'b00);
    check("abort spi_cmd", {spi_reg, spi_data_in, spi_rw}, 15'h0);
    step();
    reset = 1'b0;
    model_last = 1;
    step();
    check("abort no_rsp", {busy, req0_if.rsp_valid, req1_if.rsp_valid}, 3'b000);
    ca = '{addr: 6'h10, data: 8'h01, rw: SPI_RW_READ};
    cb = '{addr: 6'h20, data: 8'h02, rw: SPI_RW_READ};
    check("post_rst tie", pick(1'b1, 1'b1), 0);
    do_txn("post_rst_tie", 1'b1, ca, 1'b1, cb, 2, 8'h6E, 1'b0, 1'b0);
    do_txn("post_rst_host", 1'b0, ca, 1'b1, cb, 0, 8'h81, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit v0, v1, st;
      int dk;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v1 = 1'b1;
      r  = $urandom;
      ca = r[14:0];
      r  = $urandom;
      cb = r[14:0];
      r  = $urandom_range(0, 9);
      if (r == 0)      dk = -1;
      else if (r == 1) dk = TMO - 1;
      else             dk = int'($urandom_range(0, TMO - 2));
      st = 1'($urandom_range(0, 1));
      r  = $urandom;
      do_txn("rand", v0, ca, v1, cb, dk, r[7:0], st, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
